ca_gen_sequencer: RTL

- Sequential controller for the 1-D cyclic two-cell cellular automaton next-state stage.
- Holds the current generation in a register and loads a seed on start.
- Iterates next-state generations under a latched 4-bit rule for a programmed count, with optional early stop on a fixed point.
- Sits directly around the combinational rule stage: it feeds the current generation in and captures the next generation back.

---
 rtl/ca_gen_sequencer_if.sv | 29 ++
 rtl/ca_gen_sequencer.sv | 114 +++++++++++
 2 files changed

// File: rtl/ca_gen_sequencer_if.sv
// Handshake/data bundle between a controlling agent and the CA generation sequencer.
// The master drives run requests and configuration; the slave (sequencer) returns
// the current generation and run status.
interface ca_gen_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic             start;
  logic [WIDTH-1:0] seed;
  logic [3:0]       rule;
  logic [CNT_W-1:0] num_gens;
  logic             pause;
  logic [WIDTH-1:0] state_out;
  logic [CNT_W-1:0] gen_count;
  logic             gen_valid;
  logic             busy;
  logic             done;
  logic             stable;

  modport master (
    output start, seed, rule, num_gens, pause,
    input  state_out, gen_count, gen_valid, busy, done, stable
  );

  modport slave (
    input  start, seed, rule, num_gens, pause,
    output state_out, gen_count, gen_valid, busy, done, stable
  );
endinterface

// File: rtl/ca_gen_sequencer.sv
// Sequencer around the cyclic two-cell cellular automaton rule stage.
// Loads a seed, iterates generations under a latched 4-bit rule for a
// programmed count, and optionally stops early when a fixed point is reached.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_IDLE | waiting for start; outputs hold the last run's results
//   ST_RUN  | one generation per unpaused cycle until count or fixed point
//   ST_DONE | single-cycle done pulse (busy still high), then back to idle
module ca_gen_sequencer #(
  parameter int WIDTH      = 8,
  parameter int CNT_W      = 8,
  parameter bit EARLY_STOP = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  ca_gen_sequencer_if.slave     bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_fsm;
  logic [WIDTH-1:0] r_state;
  logic [3:0]       r_rule;
  logic [CNT_W-1:0] r_num_gens;
  logic [CNT_W-1:0] r_gen_count;
  logic             r_gen_valid;
  logic             r_busy;
  logic             r_done;
  logic             r_stable;

  logic [WIDTH-1:0] w_nxt;
  logic [CNT_W-1:0] w_cnt_inc;

  // Rule stage: each cell looks itself up with its upper neighbour, wrapping at the top cell.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    localparam int NB = (gi + 1) % WIDTH;
    assign w_nxt[gi] = r_rule[{r_state[NB], r_state[gi]}];
  end

  // The terminal compare uses the incremented value, so the counter never has to wrap.
  assign w_cnt_inc = r_gen_count + 1'b1;

  // Run-control FSM; all outputs are registered here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fsm       <= ST_IDLE;
      r_state     <= '0;
      r_rule      <= '0;
      r_num_gens  <= '0;
      r_gen_count <= '0;
      r_gen_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_stable    <= 1'b0;
    end else begin
      r_gen_valid <= 1'b0;
      r_done      <= 1'b0;
      case (r_fsm)
        ST_IDLE: begin
          if (bus.start) begin
            r_state     <= bus.seed;
            r_rule      <= bus.rule;
            r_num_gens  <= bus.num_gens;
            r_gen_count <= '0;
            r_stable    <= 1'b0;
            r_busy      <= 1'b1;
            if (bus.num_gens == '0) begin
              r_done <= 1'b1;
              r_fsm  <= ST_DONE;
            end else begin
              r_fsm  <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (!bus.pause) begin
            if (EARLY_STOP && (w_nxt == r_state)) begin
              // Fixed point: nothing would change, so finish without a new generation.
              r_stable <= 1'b1;
              r_done   <= 1'b1;
              r_fsm    <= ST_DONE;
            end else begin
              r_state     <= w_nxt;
              r_gen_count <= w_cnt_inc;
              r_gen_valid <= 1'b1;
              if (w_cnt_inc == r_num_gens) begin
                r_done <= 1'b1;
                r_fsm  <= ST_DONE;
              end
            end
          end
        end
        ST_DONE: begin
          r_busy <= 1'b0;
          r_fsm  <= ST_IDLE;
        end
        default: r_fsm <= ST_IDLE;
      endcase
    end
  end

  assign bus.state_out = r_state;
  assign bus.gen_count = r_gen_count;
  assign bus.gen_valid = r_gen_valid;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.stable    = r_stable;

endmodule
